ff_regfile_mp: RTL and testbench

Parametrised flip-flop register file: the next generation of the team's single-port FF storage.
- Adds multiple read and write ports, byte-enable writes, and deterministic write-conflict priority.
- Adds a synchronous clear-all, an optional registered read stage with write-to-read bypass, and out-of-range address detection.
- Used for small per-channel context/state tables where SRAM macros are too coarse.

---
 rtl/ff_regfile_mp.sv | 99 +++++++++
 tb/tb_ff_regfile_mp.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_regfile_mp.sv
// Multi-port flip-flop register file with byte-enable writes, per-byte write priority,
// synchronous clear, optional registered read stage with bypass and sticky range error.
module ff_regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int READ_LAT = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int NB      = WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic [NWR*NB-1:0]    wr_be,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_valid,
  output logic                 addr_err
);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic [WIDTH-1:0] rd_val  [NRD];
  logic [NWR-1:0]   wr_ok;
  logic [NRD-1:0]   rd_ok;
  logic             err_any;

  always_comb begin
    for (int p = 0; p < NWR; p++) wr_ok[p] = 32'(wr_addr[p*AW +: AW]) < DEPTH;
    for (int q = 0; q < NRD; q++) rd_ok[q] = 32'(rd_addr[q*AW +: AW]) < DEPTH;
    err_any = (|(wr_en & ~wr_ok)) | (|(rd_en & ~rd_ok));
  end

  // Ascending port loop: a later (higher-indexed) port overwrites earlier ones per byte.
  always_comb begin
    mem_nxt = mem;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_nxt[i] = '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wr_ok[p]) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_be[p*NB + b])
              mem_nxt[wr_addr[p*AW +: AW]][b*8 +: 8] = wr_data[p*WIDTH + b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      addr_err <= 1'b0;
    end else begin
      mem <= mem_nxt;
      if (err_any) addr_err <= 1'b1;
    end
  end

  // Bypass reads the post-edge contents, so clr and merged writes are seen in the result.
  always_comb begin
    for (int q = 0; q < NRD; q++) begin
      rd_val[q] = '0;
      if (rd_ok[q]) begin
        if (READ_LAT != 0 && BYPASS != 0) rd_val[q] = mem_nxt[rd_addr[q*AW +: AW]];
        else                              rd_val[q] = mem[rd_addr[q*AW +: AW]];
      end
    end
  end

  generate
    if (READ_LAT == 0) begin : g_comb_rd
      always_comb begin
        for (int q = 0; q < NRD; q++)
          rd_data[q*WIDTH +: WIDTH] = rd_en[q] ? rd_val[q] : '0;
        rd_valid = rd_en;
      end
    end else begin : g_reg_rd
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data  <= '0;
          rd_valid <= '0;
        end else begin
          rd_valid <= rd_en;
          for (int q = 0; q < NRD; q++)
            if (rd_en[q]) rd_data[q*WIDTH +: WIDTH] <= rd_val[q];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ff_regfile_mp.sv
// Directed bench for ff_regfile_mp: four configurations share one stimulus bus
// (default, BYPASS=0, DEPTH=12, READ_LAT=0).
module tb_ff_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;

  logic [63:0] rd_data_def, rd_data_nb, rd_data_d12, rd_data_l0;
  logic [1:0]  rd_valid_def, rd_valid_nb, rd_valid_d12, rd_valid_l0;
  logic        addr_err_def, addr_err_nb, addr_err_d12, addr_err_l0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ff_regfile_mp u_def (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_def), .rd_valid(rd_valid_def), .addr_err(addr_err_def));

  ff_regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_nb), .rd_valid(rd_valid_nb), .addr_err(addr_err_nb));

  ff_regfile_mp #(.DEPTH(12)) u_d12 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_d12), .rd_valid(rd_valid_d12), .addr_err(addr_err_d12));

  ff_regfile_mp #(.READ_LAT(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_l0), .rd_valid(rd_valid_l0), .addr_err(addr_err_l0));

  task automatic idle();
    clr = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_be = 0; rd_en = 0; rd_addr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    #1;
    n_tests++;
    if (rd_data_def !== 64'h0 || rd_valid_def !== 2'b00 || addr_err_def !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h valid=%b err=%b, expected 0/00/0",
               rd_data_def, rd_valid_def, addr_err_def);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wr_en = 2'b01; wr_addr = 8'h03; wr_data = 64'h0; wr_data[31:0] = 32'hDEADBEEF; wr_be = 8'h0F;
    @(negedge clk);
    idle();
    rd_en = 2'b10; rd_addr = 8'h30;
    @(negedge clk);
    idle();
    n_tests++;
    if (rd_data_def[63:32] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr_rd_data: got %h, expected deadbeef", rd_data_def[63:32]);
    end
    n_tests++;
    if (rd_valid_def !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_rd_valid: got %b, expected 10", rd_valid_def);
    end
  endtask

  task automatic test_byte_priority();
    @(negedge clk);
    wr_en = 2'b01; wr_addr = 8'h05; wr_data = {32'h0, 32'h11223344}; wr_be = 8'h0F;
    @(negedge clk);
    wr_en = 2'b11; wr_addr = 8'h55; wr_data = {32'hBBBBBBBB, 32'hAAAAAAAA}; wr_be = 8'h63;
    rd_en = 2'b01; rd_addr = 8'h05;
    @(negedge clk);
    idle();
    n_tests++;
    if (rd_data_def[31:0] !== 32'h11BBBBAA) begin
      n_fail++;
      $display("FAIL merge_bypass: got %h, expected 11bbbbaa", rd_data_def[31:0]);
    end
    n_tests++;
    if (rd_data_nb[31:0] !== 32'h11223344) begin
      n_fail++;
      $display("FAIL merge_nobypass: got %h, expected 11223344", rd_data_nb[31:0]);
    end
    rd_en = 2'b10; rd_addr = 8'h50;
    @(negedge clk);
    idle();
    n_tests++;
    if (rd_data_nb[63:32] !== 32'h11BBBBAA) begin
      n_fail++;
      $display("FAIL merge_stored: got %h, expected 11bbbbaa", rd_data_nb[63:32]);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr_en = 2'b01; wr_addr = 8'h07; wr_data = {32'h0, 32'h12345678}; wr_be = 8'h0F;
    rd_en = 2'b01; rd_addr = 8'h07;
    @(negedge clk);
    idle();
    n_tests++;
    if (rd_data_def[31:0] !== 32'h12345678 || rd_valid_def !== 2'b01) begin
      n_fail++;
      $display("FAIL bypass_on: got %h/%b, expected 12345678/01", rd_data_def[31:0], rd_valid_def);
    end
    n_tests++;
    if (rd_data_nb[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL bypass_off: got %h, expected 00000000", rd_data_nb[31:0]);
    end
    @(negedge clk);
    n_tests++;
    if (rd_valid_def !== 2'b00 || rd_data_def[31:0] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rd_hold: got %h/%b, expected 12345678/00", rd_data_def[31:0], rd_valid_def);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    clr = 1; wr_en = 2'b01; wr_addr = 8'h02; wr_data = 64'hFF; wr_be = 8'h0F;
    rd_en = 2'b01; rd_addr = 8'h03;
    @(negedge clk);
    idle();
    n_tests++;
    if (rd_data_def[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL clr_bypass: got %h, expected 00000000", rd_data_def[31:0]);
    end
    n_tests++;
    if (rd_data_nb[31:0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL clr_nobypass: got %h, expected deadbeef", rd_data_nb[31:0]);
    end
    for (int a = 0; a < 16; a += 2) begin
      rd_en = 2'b11; rd_addr = {4'(a + 1), 4'(a)};
      @(negedge clk);
      n_tests++;
      if (rd_data_def !== 64'h0) begin
        n_fail++;
        $display("FAIL clr_entry%0d: got %h, expected 0", a, rd_data_def);
      end
    end
    idle();
  endtask

  task automatic test_range();
    do_reset();
    @(negedge clk);
    n_tests++;
    if (addr_err_d12 !== 1'b0) begin
      n_fail++;
      $display("FAIL err_init: got %b, expected 0", addr_err_d12);
    end
    wr_en = 2'b01; wr_addr = 8'h0D; wr_data = 64'h55; wr_be = 8'h0F;
    @(negedge clk);
    idle();
    n_tests++;
    if (addr_err_d12 !== 1'b1 || addr_err_def !== 1'b0) begin
      n_fail++;
      $display("FAIL err_set: d12=%b def=%b, expected 1/0", addr_err_d12, addr_err_def);
    end
    rd_en = 2'b11; rd_addr = 8'h0E;
    @(negedge clk);
    n_tests++;
    if (rd_data_d12[31:0] !== 32'h0 || rd_valid_d12 !== 2'b11) begin
      n_fail++;
      $display("FAIL oor_read: got %h/%b, expected 0/11", rd_data_d12[31:0], rd_valid_d12);
    end
    for (int a = 0; a < 12; a += 2) begin
      rd_addr = {4'(a + 1), 4'(a)};
      @(negedge clk);
      n_tests++;
      if (rd_data_d12 !== 64'h0) begin
        n_fail++;
        $display("FAIL oor_nowrite%0d: got %h, expected 0", a, rd_data_d12);
      end
    end
    idle();
    clr = 1;
    repeat (3) @(negedge clk);
    clr = 0;
    n_tests++;
    if (addr_err_d12 !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, expected 1", addr_err_d12);
    end
    do_reset();
    n_tests++;
    if (addr_err_d12 !== 1'b0) begin
      n_fail++;
      $display("FAIL err_reset: got %b, expected 0", addr_err_d12);
    end
  endtask

  task automatic test_comb_read();
    @(negedge clk);
    wr_en = 2'b01; wr_addr = 8'h03; wr_data = {32'h0, 32'hCAFEF00D}; wr_be = 8'h0F;
    @(negedge clk);
    idle();
    rd_en = 2'b01; rd_addr = 8'h03;
    #1;
    n_tests++;
    if (rd_data_l0[31:0] !== 32'hCAFEF00D || rd_valid_l0 !== 2'b01) begin
      n_fail++;
      $display("FAIL comb_read: got %h/%b, expected cafef00d/01", rd_data_l0[31:0], rd_valid_l0);
    end
    wr_en = 2'b01; wr_data = {32'h0, 32'h0BADBEEF};
    #1;
    n_tests++;
    if (rd_data_l0[31:0] !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL comb_preedge: got %h, expected cafef00d", rd_data_l0[31:0]);
    end
    @(negedge clk);
    wr_en = 2'b00; rd_en = 2'b00;
    #1;
    n_tests++;
    if (rd_data_l0 !== 64'h0 || rd_valid_l0 !== 2'b00) begin
      n_fail++;
      $display("FAIL comb_disabled: got %h/%b, expected 0/00", rd_data_l0, rd_valid_l0);
    end
    rd_en = 2'b01;
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    n_tests++;
    if (rd_data_l0 !== 64'h0 || rd_valid_def !== 2'b00 || rd_data_def !== 64'h0) begin
      n_fail++;
      $display("FAIL async_reset: l0=%h def=%h/%b, expected 0/0/00",
               rd_data_l0, rd_data_def, rd_valid_def);
    end
    idle();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_priority();
    test_bypass();
    test_clear();
    test_range();
    test_comb_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
